// File: rtl/multicycle_control.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath.
// Define MULTICYCLE_ADDI_EN to add the ADDIEX/ADDIWR states for addi.
module multicycle_control #(
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
`ifdef MULTICYCLE_ADDI_EN
  ,
  parameter logic [5:0] OP_ADDI  = 6'b001000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12
`ifdef MULTICYCLE_ADDI_EN
    ,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
`endif
  } state_t;

  typedef struct packed {
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic [3:0] irwrite;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  function automatic state_t next_state(input state_t s, input logic [5:0] opc);
    next_state = FETCH1;
    case (s)
      FETCH1:  next_state = FETCH2;
      FETCH2:  next_state = FETCH3;
      FETCH3:  next_state = FETCH4;
      FETCH4:  next_state = DECODE;
      DECODE: begin
        if (opc == OP_LB || opc == OP_SB) next_state = MEMADR;
        else if (opc == OP_RTYPE)         next_state = RTYPEEX;
        else if (opc == OP_BEQ)           next_state = BEQEX;
        else if (opc == OP_J)             next_state = JEX;
`ifdef MULTICYCLE_ADDI_EN
        else if (opc == OP_ADDI)          next_state = ADDIEX;
`endif
        else                              next_state = FETCH1;
      end
      MEMADR:  next_state = (opc == OP_SB) ? SBWR : LBRD;
      LBRD:    next_state = LBWR;
      RTYPEEX: next_state = RTYPEWR;
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX:  next_state = ADDIWR;
`endif
      default: next_state = FETCH1;
    endcase
  endfunction

  function automatic ctrl_t decode(input state_t s);
    decode = '0;
    case (s)
      FETCH1:  begin decode.alusrcb = 2'b01; decode.pcwrite = 1'b1; decode.irwrite = 4'b0001; end
      FETCH2:  begin decode.alusrcb = 2'b01; decode.pcwrite = 1'b1; decode.irwrite = 4'b0010; end
      FETCH3:  begin decode.alusrcb = 2'b01; decode.pcwrite = 1'b1; decode.irwrite = 4'b0100; end
      FETCH4:  begin decode.alusrcb = 2'b01; decode.pcwrite = 1'b1; decode.irwrite = 4'b1000; end
      DECODE:  decode.alusrcb = 2'b11;
      MEMADR:  begin decode.alusrca = 1'b1; decode.alusrcb = 2'b10; end
      LBRD:    decode.iord = 1'b1;
      LBWR:    begin decode.regwrite = 1'b1; decode.memtoreg = 1'b1; end
      SBWR:    begin decode.iord = 1'b1; decode.memwrite = 1'b1; end
      RTYPEEX: begin decode.alusrca = 1'b1; decode.aluop = 2'b10; end
      RTYPEWR: begin decode.regdst = 1'b1; decode.regwrite = 1'b1; end
      BEQEX: begin
        decode.alusrca  = 1'b1;
        decode.aluop    = 2'b01;
        decode.branch   = 1'b1;
        decode.pcsource = 2'b01;
      end
      JEX:     begin decode.pcwrite = 1'b1; decode.pcsource = 2'b10; end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX:  begin decode.alusrca = 1'b1; decode.alusrcb = 2'b10; end
      ADDIWR:  decode.regwrite = 1'b1;
`endif
      default: decode = '0;
    endcase
  endfunction

  always_comb begin
    state_d = next_state(state_q, op);
  end

  // Outputs are registered from the next state, so ctrl_q always matches state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH1;
      ctrl_q  <= decode(FETCH1);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  // Write enables are suppressed while reset is held so an abandoned instruction leaves no trace.
  assign memwrite = ctrl_q.memwrite & ~reset;
  assign regwrite = ctrl_q.regwrite & ~reset;
  assign irwrite  = reset ? 4'b0000 : ctrl_q.irwrite;
  assign pcen     = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign aluop    = ctrl_q.aluop;
  assign pcsource = ctrl_q.pcsource;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction state sequences and
// a per-state output table, compared on every falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memwrite, iord, memtoreg, regdst, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] irwrite, state;

  int   checks = 0;
  int   errors = 0;
  logic exp_valid = 1'b0;
  int   exp_state = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .irwrite(irwrite), .pcen(pcen), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected state walk for one instruction, starting at FETCH1.
  function automatic void build_seq(input logic [5:0] o, output int seq[$]);
    seq = {0, 1, 2, 3, 4};
    case (o)
      6'b100000: seq = {seq, 5, 6, 7};
      6'b101000: seq = {seq, 5, 8};
      6'b000000: seq = {seq, 9, 10};
      6'b000100: seq = {seq, 11};
      6'b000010: seq = {seq, 12};
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: seq = {seq, 13, 14};
`endif
      default: ;
    endcase
  endfunction

  // Output table: {memwrite,iord,memtoreg,regdst,regwrite,alusrca,alusrcb,aluop,pcsource,irwrite,pcen}
  function automatic logic [16:0] model_out(input int s, input logic z, input logic r);
    logic mw, io, mt, rd, rw, as, pw, br;
    logic [1:0] bs, ao, ps;
    logic [3:0] ir;
    {mw, io, mt, rd, rw, as, pw, br} = 8'b0;
    bs = 2'b00; ao = 2'b00; ps = 2'b00; ir = 4'b0000;
    if (s >= 0 && s <= 3) begin
      bs = 2'b01; pw = 1'b1; ir = 4'(1 << s);
    end else begin
      case (s)
        4:  bs = 2'b11;
        5:  begin as = 1'b1; bs = 2'b10; end
        6:  io = 1'b1;
        7:  begin rw = 1'b1; mt = 1'b1; end
        8:  begin io = 1'b1; mw = 1'b1; end
        9:  begin as = 1'b1; ao = 2'b10; end
        10: begin rd = 1'b1; rw = 1'b1; end
        11: begin as = 1'b1; ao = 2'b01; br = 1'b1; ps = 2'b01; end
        12: begin pw = 1'b1; ps = 2'b10; end
        13: begin as = 1'b1; bs = 2'b10; end
        14: rw = 1'b1;
        default: ;
      endcase
    end
    if (r) begin
      mw = 1'b0; rw = 1'b0; ir = 4'b0000; pw = 1'b0; br = 1'b0;
    end
    return {mw, io, mt, rd, rw, as, bs, ao, ps, ir, pw | (br & z)};
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      check("state", 32'(state), 32'(exp_state));
      check($sformatf("outputs_s%0d", exp_state),
            32'({memwrite, iord, memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
                 pcsource, irwrite, pcen}),
            32'(model_out(exp_state, zero, reset)));
    end
  end

  // Called at posedge+1 with the DUT in FETCH1; returns at posedge+1 back in FETCH1.
  task automatic run_instr(input logic [5:0] o, input logic z, input int lat, input string name);
    int seq[$];
    int cyc;
    build_seq(o, seq);
    op = o;
    zero = z;
    exp_state = seq[0];
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      // op is only meaningful in DECODE/MEMADR; scramble it once it no longer matters
      if (seq[cyc-1] == 5 || (seq[cyc-1] == 4 && (cyc >= seq.size() || seq[cyc] != 5)))
        op = 6'b111111;
      exp_state = (cyc < seq.size()) ? seq[cyc] : 0;
      if (state == 4'd0 || cyc >= 16) break;
    end
    check({"latency_", name}, 32'(cyc), 32'(lat));
  endtask

  initial begin
    int seq[$];
    reset = 1'b1;
    op = 6'b100000;
    zero = 1'b0;
    @(posedge clk); #1;
    exp_state = 0;
    exp_valid = 1'b1;
    #3;
    check("reset_irwrite", 32'(irwrite), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b100000, 1'b0, 8, "lb");
    run_instr(6'b101000, 1'b1, 7, "sb");
    run_instr(6'b000000, 1'b1, 7, "rtype");
    run_instr(6'b000100, 1'b1, 6, "beq_taken");
    run_instr(6'b000100, 1'b0, 6, "beq_not_taken");
    run_instr(6'b000010, 1'b0, 6, "j");
    run_instr(6'b111111, 1'b1, 5, "undef");
`ifdef MULTICYCLE_ADDI_EN
    run_instr(6'b001000, 1'b0, 7, "addi");
`else
    run_instr(6'b001000, 1'b0, 5, "addi_disabled");
`endif

    // Reset arriving in LBWR must kill the register write immediately.
    build_seq(6'b100000, seq);
    op = 6'b100000;
    zero = 1'b0;
    exp_state = 0;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
      exp_state = seq[c];
    end
    reset = 1'b1;
    #3;
    check("lbwr_state", 32'(state), 32'd7);
    check("lbwr_reset_regwrite", 32'(regwrite), 32'd0);
    @(posedge clk); #1;
    exp_state = 0;
    #3;
    check("after_reset_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b000000, 1'b0, 7, "rtype_after_reset");

    @(negedge clk);
    exp_valid = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore control FSM that sequences the 8-bit multicycle MIPS datapath: register file, ALU, sign extension unit, PC, instruction register and the shared byte-wide memory.
- A 32-bit instruction is fetched one byte per cycle into four IR byte lanes, then decoded and executed over several cycles.
- Drives every mux select and write enable in the datapath. Sits beside the ALU decoder, which consumes aluop and funct.

Parameters:
- OP_LB, 6'b100000, load byte opcode
- OP_SB, 6'b101000, store byte opcode
- OP_RTYPE, 6'b000000, R-type opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode (used only with ADDI_EN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from the IR
- zero  input  1  ALU zero flag
- memwrite  output  1  memory byte write enable
- iord  output  1  memory address select: 0 = PC, 1 = ALU result register
- memtoreg  output  1  register write data select: 1 = memory data register
- regdst  output  1  destination register select: 1 = rd, 0 = rt
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B select: 00 = reg B, 01 = constant 1, 10 = sign-extended imm, 11 = sign-extended imm (branch offset)
- aluop  output  2  00 = add, 01 = subtract, 10 = decode by funct
- pcsource  output  2  00 = ALU result, 01 = ALU out register, 10 = jump target
- irwrite  output  4  one-hot IR byte-lane write enable
- pcen  output  1  PC write enable = pcwrite | (branch & zero)
- state  output  4  current state, for debug

Behaviour:
- State encoding: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14. Code 15 is illegal and goes to FETCH1.
- Reset: on a clk edge with reset=1, state <= FETCH1. While reset is high, memwrite, regwrite, pcen and irwrite are forced to 0 combinationally; the other outputs follow the state. Reset mid-instruction abandons it with no further writes.
- Every output not listed for a state is 0.
- Output decode per state:
  - FETCH1..FETCH4: alusrcb=01, pcwrite=1, irwrite=0001, 0010, 0100, 1000 respectively (PC += 1 each byte).
  - DECODE: alusrcb=11 (branch target into ALU out).
  - MEMADR: alusrca=1, alusrcb=10.
  - LBRD: iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, branch=1, pcsource=01.
  - JEX: pcwrite=1, pcsource=10.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWR: regwrite=1.
- Transitions:
  - FETCH1->FETCH2->FETCH3->FETCH4->DECODE.
  - DECODE: lb or sb -> MEMADR; R-type -> RTYPEEX; beq -> BEQEX; j -> JEX; addi -> ADDIEX (with ADDI_EN); any other opcode -> FETCH1, executed as a nop.
  - MEMADR: lb -> LBRD, sb -> SBWR.
  - LBRD->LBWR.
  - RTYPEEX->RTYPEWR.
  - ADDIEX->ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR -> FETCH1.
- op is sampled only in DECODE and MEMADR; op changes in other states have no effect.
- zero is used only in BEQEX; pcen = zero there.
- Latency in cycles, FETCH1 through return to FETCH1: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, undefined opcode 5.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- Defined: ADDIEX and ADDIWR exist; OP_ADDI in DECODE -> ADDIEX.
- Undefined: both states are removed; OP_ADDI falls through to the undefined-opcode path (DECODE -> FETCH1); codes 13 and 14 are illegal and go to FETCH1.

Test Plan:
- Reset held 2 cycles, then released with op=6'b100000: state=0 and irwrite=0 while reset is high; state then runs 0,1,2,3,4,5,6,7,0; irwrite 1,2,4,8 in the fetch cycles; regwrite=1 and memtoreg=1 only in state 7.
- op=6'b101000 (sb): state sequence 0..4,5,8,0; memwrite=1 and iord=1 only in state 8; regwrite never 1.
- op=6'b000100 (beq): zero=1 -> pcen=1 in state 11 with pcsource=01; repeat with zero=0 -> pcen=0 in state 11; both return to 0 after 6 cycles.
- op=6'b000010 (j): pcen=1 and pcsource=10 in state 12; op=6'b111111 -> DECODE goes straight to FETCH1, with no regwrite and no memwrite.
- op=6'b001000 with the macro defined: states 13,14, regwrite=1 and regdst=0 in state 14; macro undefined: DECODE -> FETCH1.
- Reset asserted in state 7 (LBWR): regwrite is forced 0 in that cycle and state=0 on the next edge; a forced illegal state 15 goes to 0 on the next edge.
